// File: rtl/aibio_rxcal_pkg.sv
// Shared types and constants for the RX offset-calibration controller.
// The AIBIO_RXCAL_SYNC_EN build macro is consumed by aibio_rxcal_vote.
package aibio_rxcal_pkg;

  localparam int RXCAL_CODE_W     = 8;
  localparam int RXCAL_SETTLE_DEF = 16;
  localparam int RXCAL_NSAMP_DEF  = 32;
  localparam int RXCAL_TIMER_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SET,
    ST_SETTLE,
    ST_COUNT,
    ST_DECIDE,
    ST_DONE
  } rxcal_state_e;

endpackage

// File: rtl/aibio_rxcal_vote.sv
// Per-sampler majority vote: optional 2-flop synchronizer, ones-counter, compare.
// Build macro AIBIO_RXCAL_SYNC_EN enables the input synchronizer.
module aibio_rxcal_vote #(
  parameter int NSAMP = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  input  logic rx_in,
  output logic keep_bit
);

  localparam int CNT_W = $clog2(NSAMP) + 1;

  logic             rx_s;
  logic [CNT_W-1:0] ones_q;

`ifdef AIBIO_RXCAL_SYNC_EN
  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], rx_in};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ones_q <= '0;
    else if (clr)             ones_q <= '0;
    else if (cnt_en && rx_s)  ones_q <= ones_q + CNT_W'(1);
  end

  // Strict majority: an exact tie clears the bit.
  assign keep_bit = (ones_q > CNT_W'(NSAMP / 2));

endmodule

// File: rtl/aibio_rxofs_cal_fsm.sv
// RX offset-calibration controller: 8-step SAR trim search per sampler with majority voting.
// Build macro AIBIO_RXCAL_SYNC_EN adds input synchronizers inside the vote blocks.
module aibio_rxofs_cal_fsm
  import aibio_rxcal_pkg::*;
#(
  parameter int SETTLE_CYC = RXCAL_SETTLE_DEF,
  parameter int NSAMP      = RXCAL_NSAMP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cal_start,
  input  logic       rx_out_even,
  input  logic       rx_out_odd,
  input  logic       ofs_ovrd_en,
  input  logic [7:0] ofs_ovrd_even,
  input  logic [7:0] ofs_ovrd_odd,
  output logic       rx_calen,
  output logic       rx_vref_cal,
  output logic [7:0] rx_ofscal_even,
  output logic [7:0] rx_ofscal_odd,
  output logic       cal_busy,
  output logic       cal_done
);

  rxcal_state_e             state_q, state_d;
  logic [RXCAL_TIMER_W-1:0] timer_q, timer_val;
  logic                     timer_ld;
  logic [2:0]               idx_q;
  logic [RXCAL_CODE_W-1:0]  code_even_q, code_odd_q;
  logic                     active_q, done_q;
  logic                     keep_even, keep_odd;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    timer_ld  = 1'b0;
    timer_val = '0;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (cal_start) begin
        state_d   = ST_INIT;
        timer_ld  = 1'b1;
        timer_val = RXCAL_TIMER_W'(SETTLE_CYC - 1);
      end
      ST_INIT:   if (timer_q == '0) state_d = ST_SET;
      ST_SET: begin
        state_d   = ST_SETTLE;
        timer_ld  = 1'b1;
        timer_val = RXCAL_TIMER_W'(SETTLE_CYC - 1);
      end
      ST_SETTLE: if (timer_q == '0) begin
        state_d   = ST_COUNT;
        timer_ld  = 1'b1;
        timer_val = RXCAL_TIMER_W'(NSAMP - 1);
      end
      ST_COUNT:  if (timer_q == '0) state_d = ST_DECIDE;
      ST_DECIDE: state_d = (idx_q == 3'd0) ? ST_DONE : ST_SET;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (timer_ld)            timer_q <= timer_val;
      else if (timer_q != '0)  timer_q <= timer_q - RXCAL_TIMER_W'(1);
      // Status outputs are registered from the next state so they change with the state.
      active_q <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= 3'd7;
      code_even_q <= '0;
      code_odd_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: if (cal_start) begin
          idx_q       <= 3'd7;
          code_even_q <= '0;
          code_odd_q  <= '0;
        end
        ST_SET: begin
          code_even_q[idx_q] <= 1'b1;
          code_odd_q[idx_q]  <= 1'b1;
        end
        ST_DECIDE: begin
          code_even_q[idx_q] <= keep_even;
          code_odd_q[idx_q]  <= keep_odd;
          if (idx_q != 3'd0) idx_q <= idx_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

  aibio_rxcal_vote #(.NSAMP(NSAMP)) u_vote_even (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == ST_SET),
    .cnt_en   (state_q == ST_COUNT),
    .rx_in    (rx_out_even),
    .keep_bit (keep_even)
  );

  aibio_rxcal_vote #(.NSAMP(NSAMP)) u_vote_odd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == ST_SET),
    .cnt_en   (state_q == ST_COUNT),
    .rx_in    (rx_out_odd),
    .keep_bit (keep_odd)
  );

  assign rx_calen       = active_q;
  assign rx_vref_cal    = active_q;
  assign cal_busy       = active_q;
  assign cal_done       = done_q;
  // Override mux is deliberately combinational so bring-up values apply in any state.
  assign rx_ofscal_even = ofs_ovrd_en ? ofs_ovrd_even : code_even_q;
  assign rx_ofscal_odd  = ofs_ovrd_en ? ofs_ovrd_odd  : code_odd_q;

endmodule
